// File: rtl/wb_commit_pkg.sv
// Shared constants, types and write-request decode helpers for the writeback commit stage.
package wb_commit_pkg;

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_SETX = 5'b10101;

  localparam logic [4:0]  REG_STATUS = 5'd30;
  localparam logic [4:0]  REG_LINK   = 5'd31;
  localparam logic [31:0] STATUS_MUL = 32'd4;
  localparam logic [31:0] STATUS_DIV = 32'd5;

  typedef enum logic {
    ST_IDLE,
    ST_HOLD
  } state_t;

  typedef struct packed {
    logic        en;
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_req_t;

  // r0 is hardwired, so any request aimed at it is dropped.
  function automatic wr_req_t drop_r0(input wr_req_t r);
    wr_req_t q;
    q = r;
    if (q.rd == 5'd0) q = '0;
    return q;
  endfunction

  function automatic wr_req_t pipe_req(input logic [31:0] ir, input logic [31:0] o,
                                       input logic [31:0] d, input logic [31:0] lpc,
                                       input logic [4:0] rd, input logic ex,
                                       input logic is_md);
    wr_req_t r;
    r = '0;
    if (ex) begin
      r = '{en: 1'b1, rd: REG_STATUS, data: o};
    end else if (!is_md) begin
      case (ir[31:27])
        OP_ALU, OP_ADDI: r = '{en: 1'b1, rd: rd,         data: o};
        OP_LW:           r = '{en: 1'b1, rd: rd,         data: d};
        OP_JAL:          r = '{en: 1'b1, rd: REG_LINK,   data: lpc};
        OP_SETX:         r = '{en: 1'b1, rd: REG_STATUS, data: {5'b0, ir[26:0]}};
        default:         r = '0;
      endcase
    end
    return drop_r0(r);
  endfunction

  function automatic wr_req_t md_req(input logic rdy, input logic [31:0] res,
                                     input logic [4:0] rd, input logic is_div,
                                     input logic exc);
    wr_req_t r;
    r = '0;
    if (rdy) begin
      if (exc) r = '{en: 1'b1, rd: REG_STATUS, data: (is_div ? STATUS_DIV : STATUS_MUL)};
      else     r = '{en: 1'b1, rd: rd,         data: res};
    end
    return drop_r0(r);
  endfunction

endpackage

// File: rtl/wb_commit_if.sv
// MEM/WB latch, multdiv completion and register-file write bundle for the commit stage.
interface wb_commit_if;
  logic [31:0] IR_in;
  logic [31:0] O_in;
  logic [31:0] D_in;
  logic [31:0] linked_PC_in;
  logic [4:0]  rd_in;
  logic        ex_in;
  logic        is_md_in;
  logic        md_ready;
  logic [31:0] md_result;
  logic [4:0]  md_rd;
  logic        md_is_div;
  logic        md_exception;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        wb_stall;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic [31:0] retire_count;

  modport master (
    output IR_in, O_in, D_in, linked_PC_in, rd_in, ex_in, is_md_in,
    output md_ready, md_result, md_rd, md_is_div, md_exception,
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg, wb_stall,
    input  fwd_valid, fwd_rd, fwd_data, retire_count
  );

  modport slave (
    input  IR_in, O_in, D_in, linked_PC_in, rd_in, ex_in, is_md_in,
    input  md_ready, md_result, md_rd, md_is_div, md_exception,
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg, wb_stall,
    output fwd_valid, fwd_rd, fwd_data, retire_count
  );
endinterface

// File: rtl/wb_commit_hold_buf.sv
// One-entry holding buffer for a deferred multdiv write; clear takes priority over load.
module wb_hold_buf (
  input  logic        clk,
  input  logic        clr,
  input  logic        load,
  input  logic        clear,
  input  logic [4:0]  rd_d,
  input  logic [31:0] data_d,
  output logic        valid,
  output logic [4:0]  rd,
  output logic [31:0] data
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      valid <= 1'b0;
      rd    <= '0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      rd    <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      rd    <= rd_d;
      data  <= data_d;
    end
  end

endmodule

// File: rtl/wb_commit.sv
// Writeback commit: selects pipeline data, arbitrates the regfile port against multdiv
// completions through a one-entry buffer, and counts retired writes.
module wb_commit
  import wb_commit_pkg::*;
(
  input  logic          clk,
  input  logic          clr,
  wb_commit_if.slave    bus
);

  state_t      state;
  state_t      state_nxt;
  wr_req_t     pw;
  wr_req_t     mw;
  wr_req_t     wr;
  logic        stall;
  logic        buf_load;
  logic        buf_clear;
  logic        buf_valid;
  logic [4:0]  buf_rd;
  logic [31:0] buf_data;
  logic [31:0] retire_q;

  assign pw = pipe_req(bus.IR_in, bus.O_in, bus.D_in, bus.linked_PC_in, bus.rd_in,
                       bus.ex_in, bus.is_md_in);
  assign mw = md_req(bus.md_ready, bus.md_result, bus.md_rd, bus.md_is_div, bus.md_exception);

  always_comb begin
    wr        = '0;
    stall     = 1'b0;
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    state_nxt = state;
    if (!clr) begin
      case (state)
        ST_IDLE: begin
          if (pw.en) begin
            wr = pw;
            if (mw.en) begin
              buf_load  = 1'b1;
              state_nxt = ST_HOLD;
            end
          end else if (mw.en) begin
            wr = mw;
          end
        end
        ST_HOLD: begin
          // md_ready cannot legally arrive here, so mw is not considered.
          if (!pw.en) begin
            wr        = '{en: 1'b1, rd: buf_rd, data: buf_data};
            buf_clear = 1'b1;
            state_nxt = ST_IDLE;
          end else if (pw.rd != buf_rd) begin
            wr    = pw;
            stall = 1'b1;
          end else begin
            wr        = pw;
            buf_clear = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= ST_IDLE;
      retire_q <= '0;
    end else begin
      state <= state_nxt;
      if (wr.en && !stall) retire_q <= retire_q + 32'd1;
    end
  end

  wb_hold_buf u_hold_buf (
    .clk    (clk),
    .clr    (clr),
    .load   (buf_load),
    .clear  (buf_clear),
    .rd_d   (mw.rd),
    .data_d (mw.data),
    .valid  (buf_valid),
    .rd     (buf_rd),
    .data   (buf_data)
  );

  assign bus.ctrl_writeEnable = wr.en;
  assign bus.ctrl_writeReg    = wr.rd;
  assign bus.data_writeReg    = wr.data;
  assign bus.wb_stall         = stall;
  assign bus.fwd_valid        = buf_valid;
  assign bus.fwd_rd           = buf_rd;
  assign bus.fwd_data         = buf_data;
  assign bus.retire_count     = retire_q;

endmodule

// File: tb/tb_wb_commit.sv
// Directed bench for wb_commit: plain writes, exceptions, collision/drain, stall, WAW, reset, wrap.
module tb_wb_commit;

  localparam logic [4:0] T_ALU  = 5'b00000;
  localparam logic [4:0] T_ADDI = 5'b00101;
  localparam logic [4:0] T_LW   = 5'b01000;
  localparam logic [4:0] T_JAL  = 5'b00011;
  localparam logic [4:0] T_SETX = 5'b10101;

  logic clk;
  logic clr;
  int   checks;
  int   failures;
  logic [31:0] exp_cnt;

  wb_commit_if bus ();

  wb_commit dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multdiv latency guarantees no completion while the buffer is full.
  always @(posedge clk) begin
    if (!clr) assert (!(bus.md_ready && bus.fwd_valid))
      else $error("protocol violation: md_ready while holding");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic set_pipe(input logic [4:0] op, input logic [26:0] imm, input logic [4:0] rd,
                          input logic [31:0] o, input logic [31:0] d, input logic [31:0] lpc,
                          input logic ex, input logic is_md);
    bus.IR_in        = {op, imm};
    bus.rd_in        = rd;
    bus.O_in         = o;
    bus.D_in         = d;
    bus.linked_PC_in = lpc;
    bus.ex_in        = ex;
    bus.is_md_in     = is_md;
  endtask

  task automatic set_md(input logic rdy, input logic [4:0] rd, input logic [31:0] res,
                        input logic is_div, input logic exc);
    bus.md_ready     = rdy;
    bus.md_rd        = rd;
    bus.md_result    = res;
    bus.md_is_div    = is_div;
    bus.md_exception = exc;
  endtask

  task automatic nop();
    set_pipe(T_ALU, 27'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    set_md(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic check_wr(input string tag, input logic we, input logic [4:0] rd,
                          input logic [31:0] data, input logic st);
    #1;
    check({tag, ".we"},    {31'd0, bus.ctrl_writeEnable}, {31'd0, we});
    check({tag, ".reg"},   {27'd0, bus.ctrl_writeReg},    {27'd0, rd});
    check({tag, ".data"},  bus.data_writeReg,             data);
    check({tag, ".stall"}, {31'd0, bus.wb_stall},         {31'd0, st});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_cnt  = 0;
    clr      = 1'b1;
    nop();
    #3;
    check("rst.fwd_valid", {31'd0, bus.fwd_valid}, 32'd0);
    check("rst.count", bus.retire_count, 32'd0);
    check("rst.we", {31'd0, bus.ctrl_writeEnable}, 32'd0);
    tick();
    tick();
    clr = 1'b0;

    set_pipe(T_ADDI, 27'd0, 5'd5, 32'h2A, 32'h0, 32'h0, 1'b0, 1'b0);
    check_wr("addi", 1'b1, 5'd5, 32'h2A, 1'b0);
    tick(); exp_cnt++;
    check("addi.count", bus.retire_count, exp_cnt);

    set_pipe(T_LW, 27'd0, 5'd6, 32'h1, 32'hDEAD, 32'h0, 1'b0, 1'b0);
    check_wr("lw", 1'b1, 5'd6, 32'hDEAD, 1'b0);
    tick(); exp_cnt++;

    set_pipe(T_JAL, 27'd0, 5'd9, 32'h1, 32'h2, 32'h40, 1'b0, 1'b0);
    check_wr("jal", 1'b1, 5'd31, 32'h40, 1'b0);
    tick(); exp_cnt++;

    set_pipe(T_ADDI, 27'd0, 5'd0, 32'h77, 32'h0, 32'h0, 1'b0, 1'b0);
    check_wr("r0", 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    check("r0.count", bus.retire_count, exp_cnt);

    set_pipe(T_SETX, 27'h123, 5'd3, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    check_wr("setx", 1'b1, 5'd30, 32'h123, 1'b0);
    tick(); exp_cnt++;

    set_pipe(T_ALU, 27'd0, 5'd9, 32'h1, 32'h0, 32'h0, 1'b1, 1'b0);
    check_wr("ex", 1'b1, 5'd30, 32'h1, 1'b0);
    tick(); exp_cnt++;

    set_pipe(T_ALU, 27'd0, 5'd8, 32'h5, 32'h0, 32'h0, 1'b0, 1'b1);
    check_wr("ismd", 1'b0, 5'd0, 32'h0, 1'b0);
    tick();

    nop();
    set_md(1'b1, 5'd12, 32'h1234, 1'b1, 1'b1);
    check_wr("mdexc", 1'b1, 5'd30, 32'h5, 1'b0);
    tick(); exp_cnt++;
    check("mdexc.count", bus.retire_count, exp_cnt);

    // Collision: pipeline wins, multdiv result parked.
    set_pipe(T_ADDI, 27'd0, 5'd3, 32'h3, 32'h0, 32'h0, 1'b0, 1'b0);
    set_md(1'b1, 5'd7, 32'h99, 1'b0, 1'b0);
    check_wr("coll", 1'b1, 5'd3, 32'h3, 1'b0);
    tick(); exp_cnt++;
    check("coll.fwd_valid", {31'd0, bus.fwd_valid}, 32'd1);
    check("coll.fwd_rd", {27'd0, bus.fwd_rd}, 32'd7);
    check("coll.fwd_data", bus.fwd_data, 32'h99);

    nop();
    check_wr("drain", 1'b1, 5'd7, 32'h99, 1'b0);
    tick(); exp_cnt++;
    check("drain.fwd_valid", {31'd0, bus.fwd_valid}, 32'd0);
    check("drain.count", bus.retire_count, exp_cnt);

    set_pipe(T_ADDI, 27'd0, 5'd3, 32'h3, 32'h0, 32'h0, 1'b0, 1'b0);
    set_md(1'b1, 5'd7, 32'h99, 1'b0, 1'b0);
    tick(); exp_cnt++;

    set_md(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    set_pipe(T_ADDI, 27'd0, 5'd4, 32'h44, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check_wr("stall", 1'b1, 5'd4, 32'h44, 1'b1);
      tick();
      check("stall.count", bus.retire_count, exp_cnt);
      check("stall.fwd_valid", {31'd0, bus.fwd_valid}, 32'd1);
    end

    nop();
    check_wr("unstall", 1'b1, 5'd7, 32'h99, 1'b0);
    tick(); exp_cnt++;
    check("unstall.count", bus.retire_count, exp_cnt);

    // WAW: younger pipeline write to the buffered register discards the buffer.
    set_pipe(T_ADDI, 27'd0, 5'd3, 32'h3, 32'h0, 32'h0, 1'b0, 1'b0);
    set_md(1'b1, 5'd7, 32'h99, 1'b0, 1'b0);
    tick(); exp_cnt++;
    set_md(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    set_pipe(T_ADDI, 27'd0, 5'd7, 32'h11, 32'h0, 32'h0, 1'b0, 1'b0);
    check_wr("waw", 1'b1, 5'd7, 32'h11, 1'b0);
    tick(); exp_cnt++;
    check("waw.fwd_valid", {31'd0, bus.fwd_valid}, 32'd0);
    nop();
    check_wr("waw.after", 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    check("waw.count", bus.retire_count, exp_cnt);

    // Reset mid-HOLD acts without a clock edge.
    set_pipe(T_ADDI, 27'd0, 5'd3, 32'h3, 32'h0, 32'h0, 1'b0, 1'b0);
    set_md(1'b1, 5'd7, 32'h99, 1'b0, 1'b0);
    tick();
    set_md(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    set_pipe(T_ADDI, 27'd0, 5'd4, 32'h44, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    check("hold.fwd_valid", {31'd0, bus.fwd_valid}, 32'd1);
    clr = 1'b1;
    check_wr("clr", 1'b0, 5'd0, 32'h0, 1'b0);
    check("clr.fwd_valid", {31'd0, bus.fwd_valid}, 32'd0);
    check("clr.fwd_rd", {27'd0, bus.fwd_rd}, 32'd0);
    check("clr.count", bus.retire_count, 32'd0);
    tick();
    nop();
    clr = 1'b0;
    tick();

    // Wrap: seed the counter just below the top.
    force dut.retire_q = 32'hFFFFFFFE;
    #1;
    release dut.retire_q;
    set_pipe(T_ADDI, 27'd0, 5'd5, 32'h1, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    check("wrap.max", bus.retire_count, 32'hFFFFFFFF);
    tick();
    check("wrap.zero", bus.retire_count, 32'h0);
    nop();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
